tnn_layer_sequencer: RTL and testbench
======================================

TNN_LAYER_SEQUENCER -- requirements
Module: tnn_layer_sequencer

Interface
REQ-001 The block SHALL have parameter N_NEURONS, default 8, giving the neurons evaluated per sample on one shared core (2..16).
REQ-002 The block SHALL have parameter N_IN, default 7, giving the feature lanes per sample.
REQ-003 The block SHALL have parameter IN_W, default 2, giving the bits per feature lane.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_valid  input  1  sample-present strobe.
REQ-007 Port: in_ready  output  1  block can accept a sample.
REQ-008 Port: in_data  input  N_IN*IN_W  packed features, lane 0 in LSBs (a,b,c,d,e,f,g order).
REQ-009 Port: core_in  output  N_IN*IN_W  registered operand bus to the shared combinational neuron core.
REQ-010 Port: core_out  input  1  neuron core decision bit.
REQ-011 Port: core_sel  output  $clog2(N_NEURONS)  index of the neuron currently on the core.
REQ-012 Port: out_valid  output  1  result vector valid.
REQ-013 Port: out_ready  input  1  downstream accepts result.
REQ-014 Port: out_data  output  N_NEURONS  decision bits, bit k = neuron k.
REQ-015 Port: cfg_we / cfg_addr / cfg_mask  input  1 / $clog2(N_NEURONS) / N_IN  per-neuron lane-enable mask write.
REQ-016 Port: cfg_err  output  1  one-cycle pulse on a rejected config write.

Function
REQ-017 The block SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-018 IDLE: in_ready=1; in_valid=1 captures in_data into the sample register, sets k=0 and goes to DRIVE.
REQ-019 DRIVE: core_in <= sample with lane j zeroed wherever mask[k][j]=0; core_sel <= k; next state SAMPLE.
REQ-020 SAMPLE: the block SHALL latch core_out into result bit k.
REQ-021 From SAMPLE, if k=N_NEURONS-1 the next state SHALL be DONE; otherwise k increments and the next state SHALL be DRIVE.
REQ-022 Timing: each neuron SHALL take exactly 2 cycles.
REQ-023 Latency: out_valid SHALL assert 2*N_NEURONS+1 cycles after the accepting edge.
REQ-024 DONE: out_valid=1 and out_data SHALL stay stable until out_valid&&out_ready.
REQ-025 On the DONE handshake the FSM SHALL return to IDLE; no back-to-back accept in the same cycle.
REQ-026 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE is ignored.
REQ-027 Result bits not yet evaluated SHALL read 0; the result register SHALL clear on accept.
REQ-028 Config writes SHALL be accepted only in IDLE.
REQ-029 A config write in any other state SHALL be dropped, with cfg_err=1 for exactly that cycle.
REQ-030 A config write and a sample accept in the same IDLE cycle SHALL both take effect, and the new mask SHALL apply to that sample.
REQ-031 A cfg_addr >= N_NEURONS SHALL be dropped with a cfg_err pulse.
REQ-032 core_in and core_sel SHALL hold their last values outside DRIVE.

Reset
REQ-033 rst_n low at any time SHALL set state=IDLE, k=0, in_ready=1, out_valid=0, out_data=0, core_in=0, core_sel=0 and cfg_err=0.
REQ-034 rst_n low SHALL set every mask to all-ones.
REQ-035 Reset mid-sample SHALL abort the sample with no partial output.
REQ-036 The first in_valid SHALL be honoured on the first rising edge after rst_n deasserts.

Verification
REQ-037 Scenario: N=8, default masks, core model = reference neuron, in_data=0x3FFF -> out_valid at edge 17 after accept; out_data = model result replicated (all bits equal).
REQ-038 Scenario: mask[3]=7'b0000000, mask others all-ones, core_out = OR of core_in -> out_data bit3=0, other bits 1 for nonzero input 0x0155.
REQ-039 Scenario: out_ready held 0 for 10 cycles in DONE -> out_data stable, in_ready=0, second in_valid ignored.
REQ-040 Scenario: cfg_we during DRIVE -> cfg_err=1 one cycle, mask unchanged, read back by rerunning the sample.
REQ-041 Scenario: rst_n pulsed low at k=4 -> out_valid=0, in_ready=1 the next cycle; a new sample completes correctly.
REQ-042 Scenario: cfg_we with cfg_addr=1 and in_valid in the same IDLE cycle -> neuron 1 is evaluated with the new mask on core_in.

Source files
------------

// File: rtl/tnn_layer_sequencer.sv
// Time-multiplexes one combinational neuron core across N_NEURONS neurons:
// each neuron spends one cycle driving the core and one cycle sampling its decision.
module tnn_layer_sequencer #(
  parameter int N_NEURONS = 8,
  parameter int N_IN      = 7,
  parameter int IN_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_IN*IN_W-1:0]         in_data,
  output logic [N_IN*IN_W-1:0]         core_in,
  input  logic                         core_out,
  output logic [$clog2(N_NEURONS)-1:0] core_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_NEURONS-1:0]         out_data,
  input  logic                         cfg_we,
  input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
  input  logic [N_IN-1:0]              cfg_mask,
  output logic                         cfg_err
);

  localparam int SEL_W  = $clog2(N_NEURONS);
  localparam int DATA_W = N_IN * IN_W;
  localparam logic [SEL_W-1:0] LAST_K = SEL_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       k_q, k_d;
  logic [DATA_W-1:0]      sample_q, sample_d;
  logic [N_NEURONS-1:0]   result_q, result_d;
  logic [DATA_W-1:0]      core_in_q, core_in_d;
  logic [SEL_W-1:0]       core_sel_q, core_sel_d;
  logic [N_IN-1:0]        mask_q [N_NEURONS];
  logic [DATA_W-1:0]      masked_in;
  logic                   addr_ok;
  logic                   cfg_hit;

  // Writes are honoured only while no sample is in flight, so a neuron's
  // mask can never change between its DRIVE cycle and the end of the sample.
  assign addr_ok = 32'(cfg_addr) < 32'(N_NEURONS);
  assign cfg_hit = cfg_we && (state_q == IDLE) && addr_ok;
  assign cfg_err = rst_n && cfg_we && !cfg_hit;

  always_comb begin
    masked_in = sample_q;
    for (int j = 0; j < N_IN; j++) begin
      if (!mask_q[k_q][j]) masked_in[j*IN_W +: IN_W] = '0;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sample_d   = sample_q;
    result_d   = result_q;
    core_in_d  = core_in_q;
    core_sel_d = core_sel_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sample_d = in_data;
          k_d      = '0;
          result_d = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        core_in_d  = masked_in;
        core_sel_d = k_q;
        state_d    = SAMPLE;
      end
      SAMPLE: begin
        result_d[k_q] = core_out;
        if (k_q == LAST_K) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      sample_q   <= '0;
      result_q   <= '0;
      core_in_q  <= '0;
      core_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sample_q   <= sample_d;
      result_q   <= result_d;
      core_in_q  <= core_in_d;
      core_sel_q <= core_sel_d;
    end
  end

  // NOTE: the mask array is deliberately reset so every neuron sees all lanes after reset; most memories should not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_NEURONS; n++) mask_q[n] <= '1;
    end else if (cfg_hit) begin
      mask_q[cfg_addr] <= cfg_mask;
    end
  end

  assign core_in  = core_in_q;
  assign core_sel = core_sel_q;
  assign out_data = result_q;

endmodule

// File: tb/tb_tnn_layer_sequencer.sv
// Self-checking bench for tnn_layer_sequencer: table vectors plus hand-written
// sequences for stalls, illegal config writes, mid-sample reset and same-cycle config.
module tb_tnn_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_data;
  logic [13:0] core_in;
  logic        core_out;
  logic [2:0]  core_sel;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [6:0]  cfg_mask;
  logic        cfg_err;

  int total = 0;
  int bad   = 0;
  int ecount;
  logic       core_mode;
  logic [6:0] mdl_mask [8];
  logic [7:0] sb [$];

  tnn_layer_sequencer #(.N_NEURONS(8), .N_IN(7), .IN_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_in(core_in), .core_out(core_out), .core_sel(core_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mask(cfg_mask), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Reference neuron: threshold on the lane sum; mode 0 is a plain OR of all bits.
  function automatic logic neuron(input logic mode, input logic [13:0] x);
    int s = 0;
    for (int j = 0; j < 7; j++) s += int'(x[2*j +: 2]);
    return mode ? (s >= 8) : (|x);
  endfunction

  function automatic logic [13:0] apply_mask(input logic [13:0] d, input logic [6:0] m);
    logic [13:0] r = d;
    for (int j = 0; j < 7; j++) if (!m[j]) r[2*j +: 2] = 2'b00;
    return r;
  endfunction

  function automatic logic [7:0] model(input logic mode, input logic [13:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = neuron(mode, apply_mask(d, mdl_mask[k]));
    return r;
  endfunction

  assign core_out = neuron(core_mode, core_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    ecount++;
  endtask

  // Presents a sample at a negedge in IDLE; returns at the negedge after the accepting edge.
  task automatic start_sample(input logic [13:0] d, input logic [7:0] exp);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(exp);
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    ecount   = 0;
  endtask

  // DONE is entered on the 16th edge after the accepting edge (edge 17 counting accept as 1).
  task automatic wait_done(input string name);
    while (!out_valid && ecount < 40) tick();
    check({name, "_done"}, 32'(out_valid), 32'd1);
    check({name, "_lat"}, 32'(ecount), 32'd16);
  endtask

  task automatic wait_result(input string name);
    logic [7:0] exp;
    wait_done(name);
    exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
    check({name, "_data"}, 32'(out_data), 32'(exp));
    check({name, "_inrdy_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_ovld_after"}, 32'(out_valid), 32'd0);
    check({name, "_inrdy_after"}, 32'(in_ready), 32'd1);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [6:0] m);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_mask = m;
    #1;
    check("cfg_idle_noerr", 32'(cfg_err), 32'd0);
    mdl_mask[a] = m;
    tick();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [13:0] data;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 14'h3FFF, 8'hFF};
    vecs[1] = '{1'b1, 14'h0155, 8'h00};
    vecs[2] = '{1'b0, 14'h0155, 8'hFF};
    vecs[3] = '{1'b0, 14'h0000, 8'h00};
    vecs[4] = '{1'b1, 14'h2AAA, 8'hFF};
    vecs[5] = '{1'b1, 14'h000F, 8'h00};
    vecs[6] = '{1'b1, 14'h00FF, 8'hFF};

    for (int k = 0; k < 8; k++) mdl_mask[k] = 7'h7F;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_mask = '0; core_mode = 1'b1; ecount = 0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_core_in", 32'(core_in), 32'd0);
    check("rst_core_sel", 32'(core_sel), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);

    // Release reset and present the first sample in the same cycle.
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      core_mode = vecs[i].mode;
      start_sample(vecs[i].data, vecs[i].exp);
      wait_result($sformatf("vec%0d", i));
    end

    // Neuron 3 sees no lanes; OR core.
    core_mode = 1'b0;
    cfg_write(3'd3, 7'h00);
    start_sample(14'h0155, 8'hF7);
    wait_result("mask3_zero");

    // Downstream stall: output holds, second sample ignored, no accept on handshake edge.
    begin
      logic [7:0] exp;
      start_sample(14'h0155, model(1'b0, 14'h0155));
      wait_done("stall");
      exp = sb.pop_front();
      in_valid = 1'b1;
      in_data  = 14'h0000;
      for (int c = 0; c < 10; c++) begin
        check($sformatf("stall_data%0d", c), 32'(out_data), 32'(exp));
        check($sformatf("stall_inrdy%0d", c), 32'(in_ready), 32'd0);
        check($sformatf("stall_ovld%0d", c), 32'(out_valid), 32'd1);
        tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("stall_idle_ovld", 32'(out_valid), 32'd0);
      check("stall_idle_inrdy", 32'(in_ready), 32'd1);
      tick();
      check("stall_no_accept", 32'(in_ready), 32'd1);
    end

    // Config write during DRIVE is dropped with a single-cycle error pulse.
    start_sample(14'h0155, model(1'b0, 14'h0155));
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_mask = 7'h7F;
    #1;
    check("cfg_busy_err", 32'(cfg_err), 32'd1);
    tick();
    cfg_we = 1'b0;
    #1;
    check("cfg_busy_err_end", 32'(cfg_err), 32'd0);
    wait_result("cfg_busy");
    start_sample(14'h0155, 8'hF7);
    wait_result("cfg_busy_rerun");

    // Reset while neuron 4 is on the core.
    start_sample(14'h3FFF, model(1'b0, 14'h3FFF));
    for (int c = 0; c < 9; c++) tick();
    check("midrst_sel4", 32'(core_sel), 32'd4);
    rst_n = 1'b0;
    void'(sb.pop_back());
    for (int k = 0; k < 8; k++) mdl_mask[k] = 7'h7F;
    #1;
    check("midrst_ovld", 32'(out_valid), 32'd0);
    check("midrst_inrdy", 32'(in_ready), 32'd1);
    check("midrst_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("midrst_post_inrdy", 32'(in_ready), 32'd1);
    check("midrst_post_ovld", 32'(out_valid), 32'd0);
    start_sample(14'h0155, model(1'b0, 14'h0155));
    wait_result("midrst_new");

    // Config write and accept in the same IDLE cycle: neuron 1 must use the new mask.
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_mask = 7'b0000010;
    #1;
    check("samecyc_noerr", 32'(cfg_err), 32'd0);
    mdl_mask[1] = 7'b0000010;
    start_sample(14'h3FFF, model(1'b0, 14'h3FFF));
    tick(); tick(); tick();
    check("samecyc_sel", 32'(core_sel), 32'd1);
    check("samecyc_core_in", 32'(core_in), 32'h000C);
    wait_result("samecyc");

    // Distinct per-neuron masks expose result-bit placement.
    for (int k = 0; k < 8; k++) cfg_write(3'(k), 7'(1 << (k % 7)));
    start_sample(14'h0011, model(1'b0, 14'h0011));
    check("pattern_model", 32'(model(1'b0, 14'h0011)), 32'h85);
    wait_result("pattern");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
